// File: rtl/sum_requester_if.sv
// sum_requester_if: operand, sum-unit and result handshake bundle for sum_requester
interface sum_requester_if #(parameter int W = 10);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic         valid;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_sum;
    logic         res_err;
    logic         spurious;
    logic         busy;
    modport master (
        input  in_valid, in_a, in_b, y, valid, res_ready,
        output in_ready, start, a, b, res_valid, res_sum, res_err, spurious, busy
    );
    modport slave (
        output in_valid, in_a, in_b, y, valid, res_ready,
        input  in_ready, start, a, b, res_valid, res_sum, res_err, spurious, busy
    );
endinterface

// File: rtl/sum_requester.sv
// sum_requester: FIFO-buffered start/valid sum initiator with timeout; SUM_REQUESTER_CHECK_EN adds a sum cross-check
module sum_requester #(
    parameter int W       = 10,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8
) (
    input logic             clk,
    input logic             rst,
    sum_requester_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
    state_t        state_q, state_d;
    logic [AW:0]   wp_q, wp_d, rp_q, rp_d;
    logic [W-1:0]  fa_q [DEPTH];
    logic [W-1:0]  fb_q [DEPTH];
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic          err_q, err_d, spur_q, spur_d;
    logic          empty, full, push, pop, chk_err;
    assign empty = wp_q == rp_q;
    assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign push  = bus.in_valid && bus.in_ready;
    assign pop   = (state_q == IDLE) && !empty;
`ifdef SUM_REQUESTER_CHECK_EN
    logic [W-1:0] exp_sum;
    assign exp_sum = a_q + b_q;
    assign chk_err = bus.y != exp_sum;
`else
    assign chk_err = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        err_d   = err_q;
        spur_d  = spur_q || (bus.valid && state_q != WAIT);
        wp_d    = wp_q + (AW+1)'(push);
        rp_d    = rp_q + (AW+1)'(pop);
        case (state_q)
            IDLE: if (pop) begin
                a_d     = fa_q[rp_q[AW-1:0]];
                b_d     = fb_q[rp_q[AW-1:0]];
                state_d = ISSUE;
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (bus.valid) begin
                    sum_d   = bus.y;
                    err_d   = chk_err;
                    state_d = HOLD;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    sum_d   = '0;
                    err_d   = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: state_d = bus.res_ready ? IDLE : HOLD;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            err_q   <= 1'b0;
            spur_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            err_q   <= err_d;
            spur_q  <= spur_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            fa_q[wp_q[AW-1:0]] <= bus.in_a;
            fb_q[wp_q[AW-1:0]] <= bus.in_b;
        end
    end
    assign bus.in_ready  = !full && !rst;
    assign bus.start     = state_q == ISSUE;
    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.res_valid = state_q == HOLD;
    assign bus.res_sum   = sum_q;
    assign bus.res_err   = err_q;
    assign bus.spurious  = spur_q;
    assign bus.busy      = (state_q != IDLE) || !empty;
endmodule

// File: tb/tb_sum_requester.sv
// tb_sum_requester: randomized and directed checks of sum_requester against a transaction-level model
module tb_sum_requester;
    localparam int W = 10, DEPTH = 4, TIMEOUT = 8;
`ifdef SUM_REQUESTER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    sum_requester_if #(.W(W)) bus();
    sum_requester #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));
    int checks = 0, errors = 0, cyc = 0, results = 0;
    int mode = 0;
    bit spur_req = 1'b0, spur_drv = 1'b0;
    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", n, got, exp, cyc);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // sum unit: answers one cycle after start unless mode 2; mode 1 returns a+b+1
    initial begin
        bit pend = 1'b0;
        logic [W-1:0] py = '0;
        bus.valid = 1'b0;
        bus.y = '0;
        forever begin
            tick();
            bus.valid = pend || spur_req;
            spur_drv = spur_req && !pend;
            bus.y = pend ? py : W'($urandom);
            spur_req = 1'b0;
            pend = bus.start && !rst && mode != 2;
            py = W'(bus.a + bus.b + ((mode == 1) ? 1 : 0));
        end
    end
    logic [W-1:0] qa[$], qb[$];
    initial begin
        int occ = 0, st_cyc = 0, exp_lat = 0;
        bit inflight = 1'b0, exp_spur = 1'b0, rst_seen = 1'b1, prev_start = 1'b0, prev_rv = 1'b0, eerr = 1'b0;
        logic [W-1:0] ea, eb, esum, cur_a, cur_b;
        esum = '0;
        cur_a = '0;
        cur_b = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_seen) begin
                qa.delete();
                qb.delete();
                occ = 0;
                inflight = 1'b0;
                exp_spur = 1'b0;
                cur_a = '0;
                cur_b = '0;
                prev_rv = 1'b0;
            end
            if (bus.start) begin
                chk("start_gap", prev_start, 0);
                if (qa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    ea = qa.pop_front();
                    eb = qb.pop_front();
                    cur_a = ea;
                    cur_b = eb;
                    occ--;
                    inflight = 1'b1;
                    st_cyc = cyc;
                    if (mode == 2) begin
                        esum = '0;
                        eerr = 1'b1;
                        exp_lat = TIMEOUT + 1;
                    end else begin
                        esum = W'(ea + eb + ((mode == 1) ? 1 : 0));
                        eerr = (mode == 1) && CHK;
                        exp_lat = 2;
                    end
                end
            end
            chk("a", bus.a, cur_a);
            chk("b", bus.b, cur_b);
            chk("in_ready", bus.in_ready, (!rst && occ < DEPTH));
            chk("busy", bus.busy, (occ != 0 || inflight));
            chk("spurious", bus.spurious, exp_spur);
            if (bus.res_valid && !prev_rv) begin
                if (inflight) chk("res_latency", cyc - st_cyc, exp_lat);
                else chk("res_valid_idle", bus.res_valid, 0);
            end
            if (bus.res_valid && bus.res_ready && !rst) begin
                chk("res_sum", bus.res_sum, esum);
                chk("res_err", bus.res_err, eerr);
                results++;
                inflight = 1'b0;
            end
            if (bus.in_valid && bus.in_ready && !rst) begin
                qa.push_back(bus.in_a);
                qb.push_back(bus.in_b);
                occ++;
            end
            if (bus.valid && spur_drv && !rst) exp_spur = 1'b1;
            prev_start = bus.start;
            prev_rv = bus.res_valid;
            rst_seen = rst;
        end
    end
    task automatic wait_idle();
        for (int n = 0; n < 300; n++) begin
            if (!bus.busy) break;
            tick();
        end
        if (bus.busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle got busy 1 expected 0 (cycle %0d)", cyc);
        end
    endtask
    task automatic push(input logic [W-1:0] ia, input logic [W-1:0] ib);
        bus.in_valid = 1'b1;
        bus.in_a = ia;
        bus.in_b = ib;
        for (int n = 0; n < 50 && !bus.in_ready; n++) tick();
        tick();
        bus.in_valid = 1'b0;
    endtask
    task automatic run_one(input logic [W-1:0] ia, input logic [W-1:0] ib, input int m,
                           output logic [W-1:0] sa, output logic [W-1:0] sb,
                           output logic [W-1:0] rs, output logic re, output int lat);
        int n, sc;
        wait_idle();
        mode = m;
        push(ia, ib);
        sc = -1;
        sa = '0;
        sb = '0;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.start) begin
                sa = bus.a;
                sb = bus.b;
                sc = n;
            end
            if (bus.res_valid) break;
        end
        if (!bus.res_valid) begin
            checks++;
            errors++;
            $display("FAIL run_one_wait got res_valid 0 expected 1 (cycle %0d)", cyc);
        end
        rs = bus.res_sum;
        re = bus.res_err;
        lat = n - sc;
        tick();
    endtask
    initial begin
        logic [W-1:0] sa, sb, rs, la[6], lb[6];
        logic re;
        int lat, idx, r0, sc, cnt, guard;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.res_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_start", bus.start, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_res_sum", bus.res_sum, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("rel_in_ready", bus.in_ready, 1);
        run_one(3, 5, 0, sa, sb, rs, re, lat);
        chk("single_a", sa, 3);
        chk("single_b", sb, 5);
        chk("single_sum", rs, 8);
        chk("single_err", re, 0);
        chk("single_lat", lat, 2);
        run_one(1023, 1, 0, sa, sb, rs, re, lat);
        chk("wrap_sum", rs, 0);
        chk("wrap_err", re, 0);
        run_one(10, 20, 1, sa, sb, rs, re, lat);
        chk("check_sum", rs, 31);
        chk("check_err", re, CHK);
        run_one(7, 9, 2, sa, sb, rs, re, lat);
        chk("timeout_sum", rs, 0);
        chk("timeout_err", re, 1);
        chk("timeout_lat", lat, 9);
        wait_idle();
        chk("pre_spur", bus.spurious, 0);
        spur_req = 1'b1;
        repeat (3) tick();
        chk("late_valid_spur", bus.spurious, 1);
        wait_idle();
        mode = 0;
        for (int i = 0; i < 6; i++) begin
            la[i] = W'($urandom);
            lb[i] = W'($urandom);
        end
        r0 = results;
        bus.res_ready = 1'b0;
        idx = 0;
        for (int k = 0; k < 15; k++) begin
            bit acc;
            bus.in_valid = 1'b1;
            bus.in_a = la[idx];
            bus.in_b = lb[idx];
            acc = bus.in_ready && idx < 5;
            tick();
            if (acc) idx++;
        end
        chk("bp_in_ready", bus.in_ready, 0);
        bus.res_ready = 1'b1;
        for (int k = 0; k < 80 && idx < 6; k++) begin
            bit acc;
            bus.in_a = la[idx];
            bus.in_b = lb[idx];
            acc = bus.in_ready;
            tick();
            if (acc) idx++;
        end
        bus.in_valid = 1'b0;
        chk("bp_accepted_total", idx, 6);
        wait_idle();
        chk("bp_results", results - r0, 6);
        mode = 2;
        push(11, 12);
        push(13, 14);
        push(15, 16);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_start", bus.start, 0);
        chk("mid_rst_res_valid", bus.res_valid, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        chk("mid_rst_a", bus.a, 0);
        chk("mid_rst_sum", bus.res_sum, 0);
        chk("mid_rst_err", bus.res_err, 0);
        chk("mid_rst_spur", bus.spurious, 0);
        sc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.start) sc++;
        end
        chk("no_start_after_rst", sc, 0);
        tick();
        spur_req = 1'b1;
        repeat (3) tick();
        chk("post_rst_spur", bus.spurious, 1);
        for (int bt = 0; bt < 5; bt++) begin
            wait_idle();
            mode = (bt == 3) ? 2 : int'($urandom_range(0, 1));
            cnt = 0;
            guard = 0;
            while (cnt < 30 && guard < 2000) begin
                bit acc;
                bus.in_valid = ($urandom_range(0, 2) != 0);
                bus.in_a = W'($urandom);
                bus.in_b = W'($urandom);
                bus.res_ready = ($urandom_range(0, 3) != 0);
                acc = bus.in_valid && bus.in_ready;
                tick();
                if (acc) cnt++;
                guard++;
            end
            bus.in_valid = 1'b0;
            bus.res_ready = 1'b1;
            chk("batch_pushes", cnt, 30);
        end
        wait_idle();
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
